// File: rtl/mips_pkg.sv
// Shared types and encodings for the MIPS-lite multi-cycle control unit.
package mips_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned STATE_W = 4;

  // Controller sequencing states
  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXE    = 4'd6,
    R_WB     = 4'd7,
    I_EXE    = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [FN_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FN_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FN_W-1:0] FN_AND  = 6'h24;
  localparam logic [FN_W-1:0] FN_OR   = 6'h25;
  localparam logic [FN_W-1:0] FN_SLT  = 6'h2A;

  // ALU operation encodings
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_LUI = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  // pc_source selects
  localparam logic [SEL_W-1:0] PCS_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCS_JUMP   = 2'd2;

  // reg_dst selects
  localparam logic [SEL_W-1:0] RDST_RT = 2'd0;
  localparam logic [SEL_W-1:0] RDST_RD = 2'd1;
  localparam logic [SEL_W-1:0] RDST_RA = 2'd2;

  // mem_to_reg selects
  localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] M2R_MDR    = 2'd1;
  localparam logic [SEL_W-1:0] M2R_PC     = 2'd2;

  // alu_src_b selects
  localparam logic [SEL_W-1:0] SRCB_B       = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'd3;

  // Full datapath control word driven by the controller
  typedef struct packed {
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_en;
    logic [SEL_W-1:0] pc_source;
    logic             reg_write;
    logic [SEL_W-1:0] reg_dst;
    logic [SEL_W-1:0] mem_to_reg;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic             ext_zero;
    logic [ALU_W-1:0] alu_ctrl;
    logic             retire;
    logic             halted;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU operation decode, flagging unsupported funct values.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [FN_W-1:0]  funct,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             illegal
);

  // Map funct to ALU op; unknown funct falls back to ADD and raises illegal
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct)
      FN_ADDU: alu_ctrl = ALU_ADD;
      FN_SUBU: alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control unit: sequences fetch/decode/execute over a shared datapath.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic [FN_W-1:0]  funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [SEL_W-1:0] pc_source,
  output logic             reg_write,
  output logic [SEL_W-1:0] reg_dst,
  output logic [SEL_W-1:0] mem_to_reg,
  output logic             alu_src_a,
  output logic [SEL_W-1:0] alu_src_b,
  output logic             ext_zero,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             retire,
  output logic             halted
);

  state_t           state;
  state_t           state_next;
  ctrl_t            ctrl;
  logic             pc_write;
  logic             pc_write_cond;
  logic [ALU_W-1:0] r_alu_ctrl;
  logic             r_illegal;

  mips_alu_decoder u_alu_dec (
    .funct    (funct),
    .alu_ctrl (r_alu_ctrl),
    .illegal  (r_illegal)
  );

  // State register; reset returns to FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state and control decode; outputs forced low while rst is held
  always_comb begin
    state_next    = state;
    ctrl          = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;

    case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          pc_write      = 1'b1;
          state_next    = DECODE;
        end
      end

      DECODE: begin
        // Speculatively compute the branch target into ALUOut
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:             state_next = MEM_ADDR;
          OP_RTYPE:                 state_next = R_EXE;
          OP_ADDIU, OP_ORI, OP_LUI: state_next = I_EXE;
          OP_BEQ:                   state_next = BRANCH;
          OP_J, OP_JAL:             state_next = JUMP;
          default:                  state_next = HALT;
        endcase
      end

      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_ctrl  = ALU_ADD;
        state_next     = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) state_next = MEM_WB;
      end

      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RT;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.retire     = 1'b1;
        state_next      = FETCH;
      end

      MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) begin
          ctrl.retire = 1'b1;
          state_next  = FETCH;
        end
      end

      R_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_ctrl  = r_alu_ctrl;
        state_next     = r_illegal ? HALT : R_WB;
      end

      R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.retire     = 1'b1;
        state_next      = FETCH;
      end

      I_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        case (opcode)
          OP_ORI: begin
            ctrl.alu_ctrl = ALU_OR;
            ctrl.ext_zero = 1'b1;
          end
          OP_LUI: begin
            ctrl.alu_ctrl = ALU_LUI;
            ctrl.ext_zero = 1'b1;
          end
          default: begin
            ctrl.alu_ctrl = ALU_ADD;
            ctrl.ext_zero = 1'b0;
          end
        endcase
        state_next = I_WB;
      end

      I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RDST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.retire     = 1'b1;
        state_next      = FETCH;
      end

      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_ctrl  = ALU_SUB;
        ctrl.pc_source = PCS_ALUOUT;
        ctrl.retire    = 1'b1;
        pc_write_cond  = 1'b1;
        state_next     = FETCH;
      end

      JUMP: begin
        ctrl.pc_source = PCS_JUMP;
        ctrl.retire    = 1'b1;
        pc_write       = 1'b1;
        if (opcode == OP_JAL) begin
          // PC already holds PC+4, which is the link value
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = RDST_RA;
          ctrl.mem_to_reg = M2R_PC;
        end
        state_next = FETCH;
      end

      HALT: begin
        ctrl.halted = 1'b1;
        state_next  = HALT;
      end

      default: state_next = FETCH;
    endcase

    ctrl.pc_en = pc_write | (pc_write_cond & zero);

    if (rst) ctrl = '0;
  end

  // Drive ports from the control word
  always_comb begin
    mem_req    = ctrl.mem_req;
    mem_we     = ctrl.mem_we;
    iord       = ctrl.iord;
    ir_write   = ctrl.ir_write;
    pc_en      = ctrl.pc_en;
    pc_source  = ctrl.pc_source;
    reg_write  = ctrl.reg_write;
    reg_dst    = ctrl.reg_dst;
    mem_to_reg = ctrl.mem_to_reg;
    alu_src_a  = ctrl.alu_src_a;
    alu_src_b  = ctrl.alu_src_b;
    ext_zero   = ctrl.ext_zero;
    alu_ctrl   = ctrl.alu_ctrl;
    retire     = ctrl.retire;
    halted     = ctrl.halted;
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: instruction-level model builds per-cycle expectations.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_ctrl;
    logic       retire;
    logic       halted;
  } outs_t;

  typedef struct {
    bit         rst;
    bit         mr;
    bit         z;
    logic [5:0] op;
    logic [5:0] fn;
    outs_t      exp;
    outs_t      mask;
    string      tag;
  } cyc_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_en, reg_write;
  logic       alu_src_a, ext_zero, retire, halted;
  logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_ctrl;

  cyc_t       plan[$];
  cyc_t       stim_q[$];
  cyc_t       exp_q[$];
  logic [5:0] cur_op;
  logic [5:0] cur_fn;
  int         checks = 0;
  int         errors = 0;

  mips_mc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_source  (pc_source),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_zero   (ext_zero),
    .alu_ctrl   (alu_ctrl),
    .retire     (retire),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // Append one expected cycle of the current instruction to the plan
  task automatic add(bit mr, bit z, outs_t e, outs_t m);
    cyc_t c;
    c.rst  = 1'b0;
    c.mr   = mr;
    c.z    = z;
    c.op   = cur_op;
    c.fn   = cur_fn;
    c.exp  = e;
    c.mask = m;
    c.tag  = $sformatf("op%02h_fn%02h_cyc%0d", cur_op, cur_fn, plan.size());
    plan.push_back(c);
  endtask

  task automatic add_reset();
    cyc_t c;
    c.rst  = 1'b1;
    c.mr   = rb();
    c.z    = rb();
    c.op   = 6'($urandom);
    c.fn   = 6'($urandom);
    c.exp  = '0;
    c.mask = '1;
    c.tag  = "reset";
    stim_q.push_back(c);
  endtask

  // Reference model: expected per-cycle controls of one instruction.
  // fw/mw = wait cycles before ready in fetch / data access, bz = zero flag
  // in the branch cycle, abort = row index where rst cuts the instruction.
  task automatic gen(logic [5:0] op, logic [5:0] fn, int fw, int mw, bit bz, int abort);
    outs_t e;
    outs_t full;
    outs_t nalu;
    bit    halt_tail;
    int    n;
    full = '1;
    nalu = '1;
    nalu.alu_ctrl = 3'b000;
    halt_tail = 1'b0;
    plan.delete();
    cur_op = op;
    cur_fn = fn;

    e = '0;
    e.mem_req   = 1'b1;
    e.alu_src_b = 2'd1;
    e.alu_ctrl  = 3'b010;
    for (int i = 0; i < fw; i++) add(1'b0, rb(), e, full);
    e.ir_write = 1'b1;
    e.pc_en    = 1'b1;
    add(1'b1, rb(), e, full);

    e = '0;
    e.alu_src_b = 2'd3;
    e.alu_ctrl  = 3'b010;
    add(rb(), rb(), e, full);

    case (op)
      6'h00: begin
        bit ok;
        e = '0;
        e.alu_src_a = 1'b1;
        ok = 1'b1;
        case (fn)
          6'h21:   e.alu_ctrl = 3'b010;
          6'h23:   e.alu_ctrl = 3'b110;
          6'h24:   e.alu_ctrl = 3'b000;
          6'h25:   e.alu_ctrl = 3'b001;
          6'h2A:   e.alu_ctrl = 3'b111;
          default: ok = 1'b0;
        endcase
        add(rb(), rb(), e, ok ? full : nalu);
        if (ok) begin
          e = '0;
          e.reg_write = 1'b1;
          e.reg_dst   = 2'd1;
          e.retire    = 1'b1;
          add(rb(), rb(), e, full);
        end else begin
          halt_tail = 1'b1;
        end
      end
      6'h23, 6'h2B: begin
        e = '0;
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'd2;
        e.alu_ctrl  = 3'b010;
        add(rb(), rb(), e, full);
        e = '0;
        e.mem_req = 1'b1;
        e.iord    = 1'b1;
        e.mem_we  = (op == 6'h2B);
        for (int i = 0; i < mw; i++) add(1'b0, rb(), e, full);
        e.retire = (op == 6'h2B);
        add(1'b1, rb(), e, full);
        if (op == 6'h23) begin
          e = '0;
          e.reg_write  = 1'b1;
          e.mem_to_reg = 2'd1;
          e.retire     = 1'b1;
          add(rb(), rb(), e, full);
        end
      end
      6'h09, 6'h0D, 6'h0F: begin
        e = '0;
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'd2;
        e.alu_ctrl  = (op == 6'h09) ? 3'b010 : (op == 6'h0D) ? 3'b001 : 3'b100;
        e.ext_zero  = (op != 6'h09);
        add(rb(), rb(), e, full);
        e = '0;
        e.reg_write = 1'b1;
        e.retire    = 1'b1;
        add(rb(), rb(), e, full);
      end
      6'h04: begin
        e = '0;
        e.alu_src_a = 1'b1;
        e.alu_ctrl  = 3'b110;
        e.pc_source = 2'd1;
        e.pc_en     = bz;
        e.retire    = 1'b1;
        add(rb(), bz, e, full);
      end
      6'h02, 6'h03: begin
        e = '0;
        e.pc_en     = 1'b1;
        e.pc_source = 2'd2;
        e.retire    = 1'b1;
        if (op == 6'h03) begin
          e.reg_write  = 1'b1;
          e.reg_dst    = 2'd2;
          e.mem_to_reg = 2'd2;
        end
        add(rb(), rb(), e, full);
      end
      default: halt_tail = 1'b1;
    endcase

    if (halt_tail) begin
      e = '0;
      e.halted = 1'b1;
      for (int i = 0; i < 2 + int'($urandom % 5); i++) add(rb(), rb(), e, full);
    end

    n = plan.size();
    if (abort >= 0 && abort < n) n = abort;
    for (int i = 0; i < n; i++) stim_q.push_back(plan[i]);
    if (halt_tail || n < plan.size()) add_reset();
  endtask

  // Stimulus: build the program, then drive one row per cycle and post its expectation
  initial begin
    logic [5:0] ops[9];
    logic [5:0] fns[5];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h09, 6'h0D, 6'h0F, 6'h02, 6'h03};
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
    rst = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;
    opcode = '0;
    funct = '0;

    for (int i = 0; i < 10; i++) add_reset();
    gen(6'h00, 6'h21, 0, 0, 1'b0, -1);
    gen(6'h23, 6'h00, 0, 2, 1'b0, -1);
    gen(6'h04, 6'h00, 0, 0, 1'b1, -1);
    gen(6'h04, 6'h00, 0, 0, 1'b0, -1);
    gen(6'h03, 6'h00, 0, 0, 1'b0, -1);
    gen(6'h3F, 6'h21, 0, 0, 1'b0, -1);
    gen(6'h00, 6'h00, 0, 0, 1'b0, -1);
    gen(6'h2B, 6'h00, 0, 3, 1'b0, 4);
    gen(6'h0F, 6'h00, 1, 0, 1'b0, -1);
    gen(6'h0D, 6'h00, 0, 0, 1'b0, -1);
    for (int k = 0; k < 300; k++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int         ab;
      op = ($urandom % 10 == 0) ? 6'($urandom) : ops[$urandom % 9];
      fn = ($urandom % 8 == 0) ? 6'($urandom) : fns[$urandom % 5];
      ab = ($urandom % 12 == 0) ? int'($urandom % 7) : -1;
      gen(op, fn, int'($urandom % 4), int'($urandom % 4), rb(), ab);
    end

    while (stim_q.size() > 0) begin
      cyc_t c;
      c = stim_q.pop_front();
      @(posedge clk);
      #1;
      rst       = c.rst;
      mem_ready = c.mr;
      zero      = c.z;
      opcode    = c.op;
      funct     = c.fn;
      exp_q.push_back(c);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: on each falling edge compare DUT controls with the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        cyc_t  c;
        outs_t act;
        c = exp_q.pop_front();
        act = '{mem_req, mem_we, iord, ir_write, pc_en, pc_source, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_ctrl,
                retire, halted};
        checks++;
        if ((act & c.mask) !== (c.exp & c.mask)) begin
          errors++;
          $display("FAIL %s: got %06h required %06h (mask %06h)",
                   c.tag, act, c.exp, c.mask);
        end
      end
    end
  end

endmodule
